// File: rtl/hyperbolic_cordic_vectoring_pipe.sv
// Fully pipelined 16-stage hyperbolic CORDIC in vectoring mode: z -> atanh(y/x), x -> K_h*sqrt(x^2-y^2).
// Optional macro HCORDIC_GAIN_COMP_EN appends a registered 1/K_h correction stage on x (latency 17).
module hyperbolic_cordic_vectoring_pipe #(
   parameter int data_width    = 16,
   parameter int address_width = 4,
   parameter int guard_bits    = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         ce,
   input  logic                         in_valid,
   input  logic signed [data_width-1:0] x_in,
   input  logic signed [data_width-1:0] y_in,
   output logic                         out_valid,
   output logic signed [data_width-1:0] x_out,
   output logic signed [data_width-1:0] y_out,
   output logic signed [data_width-1:0] z_out
);

   localparam int num_stages = 1 << address_width;
   localparam int xy_width   = data_width + guard_bits;

   // Each address already folds in the repeated shifts, so entry k is atanh(2^-s(k)) in Q2.14.
   function automatic logic signed [data_width-1:0] atanh_rom(input logic [address_width-1:0] addr);
      logic signed [data_width-1:0] val;
      case (addr)
         4'd0:    val = 16'sd9000;
         4'd1:    val = 16'sd4185;
         4'd2:    val = 16'sd2059;
         4'd3:    val = 16'sd1025;
         4'd4:    val = 16'sd1025;
         4'd5:    val = 16'sd512;
         4'd6:    val = 16'sd256;
         4'd7:    val = 16'sd128;
         4'd8:    val = 16'sd64;
         4'd9:    val = 16'sd32;
         4'd10:   val = 16'sd16;
         4'd11:   val = 16'sd8;
         4'd12:   val = 16'sd4;
         4'd13:   val = 16'sd2;
         4'd14:   val = 16'sd2;
         4'd15:   val = 16'sd1;
         default: val = 16'sd0;
      endcase
      return val;
   endfunction

   function automatic int stage_shift(input int k);
      int s;
      if (k < 4) begin
         s = k + 1;
      end else if (k < 14) begin
         s = k;
      end else begin
         s = k - 1;
      end
      return s;
   endfunction

   logic signed [xy_width-1:0]   x_r     [num_stages+1];
   logic signed [xy_width-1:0]   y_r     [num_stages+1];
   logic signed [data_width-1:0] z_r     [num_stages+1];
   logic [num_stages:0]          v_r;
   logic signed [xy_width-1:0]   x_nxt_s [num_stages];
   logic signed [xy_width-1:0]   y_nxt_s [num_stages];
   logic signed [data_width-1:0] z_nxt_s [num_stages];

   // Rotation step for every stage; both x and y updates use the old values.
   always_comb begin
      x_nxt_s = '{default: '0};
      y_nxt_s = '{default: '0};
      z_nxt_s = '{default: '0};
      for (int k = 0; k < num_stages; k++) begin
         if (!y_r[k][xy_width-1]) begin
            x_nxt_s[k] = x_r[k] - (y_r[k] >>> stage_shift(k));
            y_nxt_s[k] = y_r[k] - (x_r[k] >>> stage_shift(k));
            z_nxt_s[k] = z_r[k] + atanh_rom(k[address_width-1:0]);
         end else begin
            x_nxt_s[k] = x_r[k] + (y_r[k] >>> stage_shift(k));
            y_nxt_s[k] = y_r[k] + (x_r[k] >>> stage_shift(k));
            z_nxt_s[k] = z_r[k] - atanh_rom(k[address_width-1:0]);
         end
      end
   end

   // Input register plus 16 iteration registers with valid travelling alongside.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k <= num_stages; k++) begin
            x_r[k] <= '0;
            y_r[k] <= '0;
            z_r[k] <= '0;
         end
         v_r <= '0;
      end else if (ce) begin
         x_r[0] <= {x_in, {guard_bits{1'b0}}};
         y_r[0] <= {y_in, {guard_bits{1'b0}}};
         z_r[0] <= '0;
         for (int k = 0; k < num_stages; k++) begin
            x_r[k+1] <= x_nxt_s[k];
            y_r[k+1] <= y_nxt_s[k];
            z_r[k+1] <= z_nxt_s[k];
         end
         v_r <= {v_r[num_stages-1:0], in_valid};
      end
   end

`ifdef HCORDIC_GAIN_COMP_EN
   localparam int                          frac_bits  = data_width - 2;
   localparam logic signed [data_width-1:0] inv_gain  = 16'sh4D48;
   localparam logic signed [2*data_width-1:0] round_half = (2*data_width)'(1) << (frac_bits - 1);

   logic signed [data_width-1:0]   x_trunc_s;
   logic signed [2*data_width-1:0] x_rnd_s;
   logic signed [data_width-1:0]   xg_r;
   logic signed [data_width-1:0]   yg_r;
   logic signed [data_width-1:0]   zg_r;
   logic                           vg_r;
   logic                           unused_bits_s;

   // Q2.14 x Q2.14 product, rounded half-up back to Q2.14.
   always_comb begin
      x_trunc_s = x_r[num_stages][xy_width-1:guard_bits];
      x_rnd_s   = (x_trunc_s * inv_gain) + round_half;
   end

   // Gain-correction stage; y, z and valid are delayed by one to stay aligned.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         xg_r <= '0;
         yg_r <= '0;
         zg_r <= '0;
         vg_r <= 1'b0;
      end else if (ce) begin
         xg_r <= x_rnd_s[frac_bits+data_width-1:frac_bits];
         yg_r <= y_r[num_stages][xy_width-1:guard_bits];
         zg_r <= z_r[num_stages];
         vg_r <= v_r[num_stages];
      end
   end

   assign unused_bits_s = ^{x_r[num_stages][guard_bits-1:0], y_r[num_stages][guard_bits-1:0],
                            x_rnd_s[2*data_width-1:frac_bits+data_width], x_rnd_s[frac_bits-1:0]};
   assign out_valid = vg_r;
   assign x_out     = xg_r;
   assign y_out     = yg_r;
   assign z_out     = zg_r;
`else
   logic unused_bits_s;

   assign unused_bits_s = ^{x_r[num_stages][guard_bits-1:0], y_r[num_stages][guard_bits-1:0]};
   assign out_valid = v_r[num_stages];
   assign x_out     = x_r[num_stages][xy_width-1:guard_bits];
   assign y_out     = y_r[num_stages][xy_width-1:guard_bits];
   assign z_out     = z_r[num_stages];
`endif

endmodule

// File: tb/tb_hyperbolic_cordic_vectoring_pipe.sv
// Directed bench for hyperbolic_cordic_vectoring_pipe: latency, accuracy, streaming, ce hold, async reset.
module tb_hyperbolic_cordic_vectoring_pipe;

`ifdef HCORDIC_GAIN_COMP_EN
   localparam int lat       = 17;
   localparam bit gain_comp = 1'b1;
`else
   localparam int lat       = 16;
   localparam bit gain_comp = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        ce;
   logic        in_valid;
   logic [15:0] x_in;
   logic [15:0] y_in;
   logic        out_valid;
   logic [15:0] x_out;
   logic [15:0] y_out;
   logic [15:0] z_out;

   int  n_cmp  = 0;
   int  n_fail = 0;
   real kh;

   hyperbolic_cordic_vectoring_pipe dut (
      .clk       (clk),
      .rst       (rst),
      .ce        (ce),
      .in_valid  (in_valid),
      .x_in      (x_in),
      .y_in      (y_in),
      .out_valid (out_valid),
      .x_out     (x_out),
      .y_out     (y_out),
      .z_out     (z_out)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   function automatic int sdist(input logic [15:0] a, input logic [15:0] b);
      int d;
      d = int'($signed(a)) - int'($signed(b));
      return (d < 0) ? -d : d;
   endfunction

   function automatic real model_z(input int xv, input int yv);
      real r;
      r = $itor(yv) / $itor(xv);
      return 0.5 * $ln((1.0 + r) / (1.0 - r)) * 16384.0;
   endfunction

   function automatic real model_x(input int xv, input int yv);
      real m;
      m = $sqrt($itor(xv) * $itor(xv) - $itor(yv) * $itor(yv));
      return gain_comp ? m : kh * m;
   endfunction

   task automatic run_single(input logic [15:0] xi, input logic [15:0] yi, output int lat_o,
                             output logic [15:0] xo, output logic [15:0] yo, output logic [15:0] zo);
      @(negedge clk);
      x_in = xi; y_in = yi; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      lat_o = 0;
      while (out_valid !== 1'b1 && lat_o < 40) begin
         @(negedge clk);
         lat_o++;
      end
      xo = x_out; yo = y_out; zo = z_out;
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_fail++; $display("FAIL single_pulse: out_valid=%b required 0", out_valid);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; ce = 1'b1; in_valid = 1'b0; x_in = 16'h4000; y_in = 16'h0000;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({out_valid, x_out, y_out, z_out} !== 49'd0) begin
         n_fail++; $display("FAIL reset_state: v=%b x=%h y=%h z=%h required all 0", out_valid, x_out, y_out, z_out);
      end
      rst = 1'b0;
      for (int c = 0; c < lat + 4; c++) begin
         @(negedge clk);
         n_cmp++;
         if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL idle_valid: cycle %0d out_valid=%b required 0", c, out_valid);
         end
      end
   endtask

   task automatic test_single_vectors();
      int          l;
      logic [15:0] xo, yo, zo, x_exp;
      // atanh(0) case
      run_single(16'h4000, 16'h0000, l, xo, yo, zo);
      x_exp = gain_comp ? 16'h4000 : 16'h3500;
      n_cmp++; if (l !== lat) begin n_fail++; $display("FAIL latency_a: got %0d required %0d", l, lat); end
      n_cmp++; if (sdist(zo, 16'h0000) > 1) begin n_fail++; $display("FAIL z_a: got %h required 0000+/-1", zo); end
      n_cmp++; if (sdist(yo, 16'h0000) > 2) begin n_fail++; $display("FAIL y_a: got %h required 0000+/-2", yo); end
      n_cmp++; if (sdist(xo, x_exp) > 4) begin n_fail++; $display("FAIL x_a: got %h required %h+/-4", xo, x_exp); end
      // atanh(0.5)
      run_single(16'h4000, 16'h2000, l, xo, yo, zo);
      x_exp = gain_comp ? 16'h376D : 16'h2DE7;
      n_cmp++; if (l !== lat) begin n_fail++; $display("FAIL latency_b: got %0d required %0d", l, lat); end
      n_cmp++; if (sdist(zo, 16'h2328) > 3) begin n_fail++; $display("FAIL z_b: got %h required 2328+/-3", zo); end
      n_cmp++; if (sdist(yo, 16'h0000) > 2) begin n_fail++; $display("FAIL y_b: got %h required 0000+/-2", yo); end
      n_cmp++; if (sdist(xo, x_exp) > 4) begin n_fail++; $display("FAIL x_b: got %h required %h+/-4", xo, x_exp); end
      // atanh(-0.5)
      run_single(16'h4000, 16'hE000, l, xo, yo, zo);
      n_cmp++; if (l !== lat) begin n_fail++; $display("FAIL latency_c: got %0d required %0d", l, lat); end
      n_cmp++; if (sdist(zo, 16'hDCD8) > 3) begin n_fail++; $display("FAIL z_c: got %h required DCD8+/-3", zo); end
      n_cmp++; if (sdist(yo, 16'h0000) > 2) begin n_fail++; $display("FAIL y_c: got %h required 0000+/-2", yo); end
      n_cmp++; if (sdist(xo, x_exp) > 4) begin n_fail++; $display("FAIL x_c: got %h required %h+/-4", xo, x_exp); end
   endtask

   task automatic test_back_to_back();
      int  xs [32];
      int  ys [32];
      int  ymax;
      int  n_out = 0;
      real dz, dx, dy;
      for (int i = 0; i < 32; i++) begin
         xs[i] = int'($urandom_range(32'h6000, 32'h2000));
         ymax  = (xs[i] * 3) / 4;
         ys[i] = int'($urandom_range(2 * ymax, 0)) - ymax;
      end
      for (int t = 0; t < 32 + lat + 3; t++) begin
         @(negedge clk);
         if (out_valid === 1'b1) begin
            n_cmp++;
            if (t !== n_out + lat + 1) begin
               n_fail++; $display("FAIL b2b_timing: sample %0d at cycle %0d required %0d", n_out, t, n_out + lat + 1);
            end
            if (n_out < 32) begin
               dz = $itor($signed(z_out)) - model_z(xs[n_out], ys[n_out]);
               dx = $itor($signed(x_out)) - model_x(xs[n_out], ys[n_out]);
               dy = $itor($signed(y_out));
               n_cmp++;
               if (dz > 4.0 || dz < -4.0 || dx > 4.0 || dx < -4.0 || dy > 4.0 || dy < -4.0) begin
                  n_fail++;
                  $display("FAIL b2b_value: sample %0d x=%h y=%h z=%h required x=%0.1f y=0 z=%0.1f (+/-4)",
                           n_out, x_out, y_out, z_out, model_x(xs[n_out], ys[n_out]), model_z(xs[n_out], ys[n_out]));
               end
            end
            n_out++;
         end
         if (t < 32) begin
            x_in = 16'(xs[t]); y_in = 16'(ys[t]); in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
      end
      n_cmp++;
      if (n_out !== 32) begin n_fail++; $display("FAIL b2b_count: got %0d pulses required 32", n_out); end
   endtask

   task automatic test_ce_hold();
      int c;
      logic [15:0] x_exp;
      x_exp = gain_comp ? 16'h4000 : 16'h3500;
      @(negedge clk); x_in = 16'h4000; y_in = 16'h0000; in_valid = 1'b1;
      @(negedge clk); y_in = 16'h2000;
      @(negedge clk); y_in = 16'hE000;
      @(negedge clk); in_valid = 1'b0;
      c = 0;
      while (out_valid !== 1'b1 && c < 40) begin
         @(negedge clk);
         c++;
      end
      n_cmp++;
      if (out_valid !== 1'b1 || sdist(z_out, 16'h0000) > 1) begin
         n_fail++; $display("FAIL ce_first: v=%b z=%h required 1 / 0000", out_valid, z_out);
      end
      ce = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_cmp++;
         if (out_valid !== 1'b1 || sdist(z_out, 16'h0000) > 1 || sdist(x_out, x_exp) > 4) begin
            n_fail++; $display("FAIL ce_frozen: cycle %0d v=%b x=%h z=%h required 1 / %h / 0000", i, out_valid, x_out, z_out, x_exp);
         end
      end
      ce = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1 || sdist(z_out, 16'h2328) > 3) begin
         n_fail++; $display("FAIL ce_second: v=%b z=%h required 1 / 2328", out_valid, z_out);
      end
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1 || sdist(z_out, 16'hDCD8) > 3) begin
         n_fail++; $display("FAIL ce_third: v=%b z=%h required 1 / DCD8", out_valid, z_out);
      end
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ce_no_dup: v=%b required 0", out_valid); end
      repeat (lat + 2) @(negedge clk);
   endtask

   task automatic test_reset_midstream();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         x_in = 16'h4000; y_in = 16'(i * 256); in_valid = 1'b1;
      end
      @(negedge clk);
      in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      n_cmp++;
      if ({out_valid, x_out, y_out, z_out} !== 49'd0) begin
         n_fail++; $display("FAIL async_reset: v=%b x=%h y=%h z=%h required all 0", out_valid, x_out, y_out, z_out);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      x_in = 16'h4000; y_in = 16'h2000; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      for (int c = 0; c < lat; c++) begin
         n_cmp++;
         if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL post_reset_quiet: cycle %0d out_valid=%b required 0", c, out_valid);
         end
         @(negedge clk);
      end
      n_cmp++;
      if (out_valid !== 1'b1 || sdist(z_out, 16'h2328) > 3) begin
         n_fail++; $display("FAIL post_reset_sample: v=%b z=%h required 1 / 2328", out_valid, z_out);
      end
   endtask

   initial begin
      int shifts [16];
      real p;
      shifts = '{1, 2, 3, 4, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 13, 14};
      kh = 1.0;
      for (int k = 0; k < 16; k++) begin
         p = 1.0;
         for (int j = 0; j < 2 * shifts[k]; j++) p = p / 2.0;
         kh = kh * $sqrt(1.0 - p);
      end
      test_reset();
      test_single_vectors();
      test_back_to_back();
      test_ce_hold();
      test_reset_midstream();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
